// File: rtl/ct_lsu_idalloc_8.sv
// Lowest-free ID allocator for the LSU 8-entry ID FIFO, with a gated local clock.
// Grant is combinational from the busy register; busy/free_cnt/err update one edge later.

// Purpose: latch-based clock gate; the enable is captured while clk_in is low.
// Latency: none; clk_out follows clk_in whenever the latched enable is set.
// Backpressure: none; purely a clock gate.
module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic external_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);
   logic clk_en_bf_latch;
   logic clk_en;

   assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

   always_latch begin
      if (!clk_in)
         clk_en = clk_en_bf_latch | pad_yy_icg_scan_en;
   end

   assign clk_out = clk_in & clk_en;
endmodule

// Purpose: free-list allocator issuing the lowest free 3-bit ID; one-hot multi-ID release.
// Latency: grant and ID are zero-latency; a released ID is allocatable the next cycle.
// Backpressure: grant drops while full; there is no queuing and the requester retries.
module ct_lsu_idalloc_8 (
   input  logic       forever_cpuclk,
   input  logic       cpurst_b,
   input  logic       cp0_lsu_icg_en,
   input  logic       cp0_yy_clk_en,
   input  logic       pad_yy_icg_scan_en,
   input  logic       idalloc_alloc_req,
   output logic       idalloc_alloc_gnt,
   output logic [2:0] idalloc_alloc_id,
   output logic [7:0] idalloc_alloc_id_oh,
   input  logic       idalloc_release_vld,
   input  logic [7:0] idalloc_release_id_oh,
   output logic [7:0] idalloc_busy,
   output logic [3:0] idalloc_free_cnt,
   output logic       idalloc_full,
   output logic       idalloc_all_free,
   output logic       idalloc_err_double_free
);
   localparam int ENTRY = 8;
   localparam int ID_W  = 3;

   logic             idalloc_clk;
   logic             idalloc_clk_en;
   logic [ENTRY-1:0] busy;
   logic [3:0]       free_cnt;
   logic             err_double_free;
   logic [ID_W-1:0]  sel_id;
   logic [ENTRY-1:0] sel_oh;
   logic [ENTRY-1:0] rel_raw;
   logic [ENTRY-1:0] rel_mask;
   logic [ENTRY-1:0] busy_nxt;
   logic [3:0]       busy_pop;
   logic [3:0]       free_cnt_nxt;
   logic             dbl_nxt;
   logic             gnt;

   // Reset must always see an edge, and a pending error pulse needs one more edge to clear.
   assign idalloc_clk_en = idalloc_alloc_req | idalloc_release_vld
                         | err_double_free | ~cpurst_b;

   gated_clk_cell x_idalloc_gated_clk (
      .clk_in             (forever_cpuclk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_lsu_icg_en),
      .local_en           (idalloc_clk_en),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (idalloc_clk)
   );

   // Scanning downward leaves the lowest free index; stays 0 when everything is busy.
   always_comb begin
      sel_id = '0;
      for (int i = ENTRY - 1; i >= 0; i--) begin
         if (!busy[i])
            sel_id = i[ID_W-1:0];
      end
   end

   assign gnt    = idalloc_alloc_req & ~idalloc_full;
   assign sel_oh = (ENTRY'(1) << sel_id) & {ENTRY{gnt}};

   // Only busy IDs are released; a free one (including the one granted now) is a double free.
   assign rel_raw  = idalloc_release_vld ? idalloc_release_id_oh : '0;
   assign rel_mask = rel_raw & busy;
   assign dbl_nxt  = |(rel_raw & ~busy);
   assign busy_nxt = (busy & ~rel_mask) | sel_oh;

   always_comb begin
      busy_pop = '0;
      for (int i = 0; i < ENTRY; i++)
         busy_pop = busy_pop + {3'b000, busy_nxt[i]};
      free_cnt_nxt = 4'(ENTRY) - busy_pop;
   end

   always_ff @(posedge idalloc_clk) begin
      if (!cpurst_b) begin
         busy            <= '0;
         free_cnt        <= 4'(ENTRY);
         err_double_free <= 1'b0;
      end else begin
         busy            <= busy_nxt;
         free_cnt        <= free_cnt_nxt;
         err_double_free <= dbl_nxt;
      end
   end

   assign idalloc_alloc_gnt       = gnt;
   assign idalloc_alloc_id        = sel_id;
   assign idalloc_alloc_id_oh     = sel_oh;
   assign idalloc_busy            = busy;
   assign idalloc_free_cnt        = free_cnt;
   assign idalloc_full            = (free_cnt == 4'd0);
   assign idalloc_all_free        = (free_cnt == 4'(ENTRY));
   assign idalloc_err_double_free = err_double_free;
endmodule

// File: tb/tb_ct_lsu_idalloc_8.sv
// Bench for ct_lsu_idalloc_8: table of per-cycle vectors plus hand sequences for reset/mid-op cases.
module tb_ct_lsu_idalloc_8;
   logic       forever_cpuclk;
   logic       cpurst_b;
   logic       cp0_lsu_icg_en;
   logic       cp0_yy_clk_en;
   logic       pad_yy_icg_scan_en;
   logic       idalloc_alloc_req;
   logic       idalloc_alloc_gnt;
   logic [2:0] idalloc_alloc_id;
   logic [7:0] idalloc_alloc_id_oh;
   logic       idalloc_release_vld;
   logic [7:0] idalloc_release_id_oh;
   logic [7:0] idalloc_busy;
   logic [3:0] idalloc_free_cnt;
   logic       idalloc_full;
   logic       idalloc_all_free;
   logic       idalloc_err_double_free;

   ct_lsu_idalloc_8 dut (
      .forever_cpuclk          (forever_cpuclk),
      .cpurst_b                (cpurst_b),
      .cp0_lsu_icg_en          (cp0_lsu_icg_en),
      .cp0_yy_clk_en           (cp0_yy_clk_en),
      .pad_yy_icg_scan_en      (pad_yy_icg_scan_en),
      .idalloc_alloc_req       (idalloc_alloc_req),
      .idalloc_alloc_gnt       (idalloc_alloc_gnt),
      .idalloc_alloc_id        (idalloc_alloc_id),
      .idalloc_alloc_id_oh     (idalloc_alloc_id_oh),
      .idalloc_release_vld     (idalloc_release_vld),
      .idalloc_release_id_oh   (idalloc_release_id_oh),
      .idalloc_busy            (idalloc_busy),
      .idalloc_free_cnt        (idalloc_free_cnt),
      .idalloc_full            (idalloc_full),
      .idalloc_all_free        (idalloc_all_free),
      .idalloc_err_double_free (idalloc_err_double_free)
   );

   typedef struct {
      logic       req;
      logic       rv;
      logic [7:0] roh;
      logic       gnt;
      logic [2:0] id;
      logic [7:0] busy;
      logic [3:0] cnt;
      logic       err;
   } vec_t;

   typedef struct {
      logic [7:0] busy;
      logic [3:0] cnt;
      logic       err;
   } exp_t;

   vec_t tbl[25];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   initial begin
      forever_cpuclk = 1'b0;
      forever #5 forever_cpuclk = ~forever_cpuclk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, check the combinational grant, then check registered state after the edge.
   task automatic step(input logic rst, input logic req, input logic rv, input logic [7:0] roh,
                       input logic egnt, input logic [2:0] eid,
                       input logic [7:0] ebusy, input logic [3:0] ecnt, input logic eerr);
      exp_t       e;
      logic [7:0] one;
      logic [7:0] eoh;
      cpurst_b              = rst;
      idalloc_alloc_req     = req;
      idalloc_release_vld   = rv;
      idalloc_release_id_oh = roh;
      #1;
      one = 8'h01;
      eoh = egnt ? (one << eid) : 8'h00;
      chk("gnt", {31'd0, idalloc_alloc_gnt}, {31'd0, egnt});
      chk("alloc_id", {29'd0, idalloc_alloc_id}, {29'd0, eid});
      chk("alloc_id_oh", {24'd0, idalloc_alloc_id_oh}, {24'd0, eoh});
      e.busy = ebusy;
      e.cnt  = ecnt;
      e.err  = eerr;
      sb.push_back(e);
      @(posedge forever_cpuclk);
      #2;
      e = sb.pop_front();
      chk("busy", {24'd0, idalloc_busy}, {24'd0, e.busy});
      chk("free_cnt", {28'd0, idalloc_free_cnt}, {28'd0, e.cnt});
      chk("full", {31'd0, idalloc_full}, {31'd0, e.cnt == 4'd0});
      chk("all_free", {31'd0, idalloc_all_free}, {31'd0, e.cnt == 4'd8});
      chk("err_double_free", {31'd0, idalloc_err_double_free}, {31'd0, e.err});
   endtask

   initial begin
      //            req   rv    roh    gnt   id    busy   cnt   err
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01, 4'd7, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h03, 4'd6, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 8'h07, 4'd5, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd3, 8'h0F, 4'd4, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 8'h1F, 4'd3, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd5, 8'h3F, 4'd2, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd6, 8'h7F, 4'd1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd7, 8'hFF, 4'd0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 4'd0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 8'h24, 1'b0, 3'd0, 8'hDB, 4'd2, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 8'hDF, 4'd1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd5, 8'hFF, 4'd0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 4'd0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 8'h00, 4'd8, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01, 4'd7, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h03, 4'd6, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 8'h07, 4'd5, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd3, 8'h0F, 4'd4, 1'b0};
      tbl[18] = '{1'b0, 1'b1, 8'h30, 1'b0, 3'd4, 8'h0F, 4'd4, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 8'h0F, 4'd4, 1'b0};
      tbl[20] = '{1'b1, 1'b1, 8'h01, 1'b1, 3'd4, 8'h1E, 4'd4, 1'b0};
      tbl[21] = '{1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 8'h1E, 4'd4, 1'b0};
      tbl[22] = '{1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 8'h1F, 4'd3, 1'b1};
      tbl[23] = '{1'b1, 1'b1, 8'h12, 1'b1, 3'd5, 8'h2D, 4'd4, 1'b0};
      tbl[24] = '{1'b0, 1'b1, 8'h2D, 1'b0, 3'd1, 8'h00, 4'd8, 1'b0};

      cpurst_b              = 1'b0;
      cp0_lsu_icg_en        = 1'b0;
      cp0_yy_clk_en         = 1'b1;
      pad_yy_icg_scan_en    = 1'b0;
      idalloc_alloc_req     = 1'b0;
      idalloc_release_vld   = 1'b0;
      idalloc_release_id_oh = 8'h00;
      repeat (2) @(posedge forever_cpuclk);
      #2;
      chk("rst_busy", {24'd0, idalloc_busy}, 32'h00);
      chk("rst_free_cnt", {28'd0, idalloc_free_cnt}, 32'd8);
      chk("rst_full", {31'd0, idalloc_full}, 32'd0);
      chk("rst_all_free", {31'd0, idalloc_all_free}, 32'd1);
      chk("rst_err", {31'd0, idalloc_err_double_free}, 32'd0);

      for (int v = 0; v < 25; v++)
         step(1'b1, tbl[v].req, tbl[v].rv, tbl[v].roh,
              tbl[v].gnt, tbl[v].id, tbl[v].busy, tbl[v].cnt, tbl[v].err);

      // Fill to all-busy, carve out 8'hA5, then reset mid-operation with req and release active.
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'(i), 8'((1 << (i + 1)) - 1), 4'(7 - i), 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 3'd0, 8'hA5, 4'd4, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd1, 8'h00, 4'd8, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 8'h01, 4'd7, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
